i2s2_frame_ctrl: RTL and testbench
==================================

Name: i2s2_frame_ctrl

Overview:
- I2S frame controller for the Pmod I2S2 (CS4344 DAC, CS5343 ADC) running in the 22.58 MHz MCLK domain from the codec clock-and-reset block.
- Derives SCLK and LRCK from MCLK by counting, serialises stereo DAC samples and deserialises stereo ADC samples.
- Exchanges samples with the rest of the design through valid/ready stereo-pair interfaces.
- MCLK forwarding to the pins is done outside this block.

Parameters:
- DATA_WIDTH, 24, sample width per channel; legal range 8..31.
- MCLK_PER_SCLK, 8, MCLK cycles per SCLK period; power of two, at least 4. Frame is fixed at 64 SCLK, so MCLK/LRCK = 64*MCLK_PER_SCLK (512, i.e. 44.1 kHz at 22.58 MHz).

Ports:
- clk  in  1  MCLK-domain clock (the BUFG'd clk_mclk).
- rst  in  1  synchronous reset, active-high.
- cfg_enable  in  1  run/stop; level-sensitive.
- cmd_clear_status  in  1  one-cycle pulse, clears sticky flags.
- tx_left  in  DATA_WIDTH  DAC left sample, two's complement.
- tx_right  in  DATA_WIDTH  DAC right sample.
- tx_valid  in  1  TX pair valid.
- tx_ready  out  1  TX pair accepted this cycle.
- rx_left  out  DATA_WIDTH  ADC left sample.
- rx_right  out  DATA_WIDTH  ADC right sample.
- rx_valid  out  1  RX pair valid.
- rx_ready  in  1  RX pair consumed.
- da_lrck, da_sclk, da_sdin  out  1 each  DAC pins.
- ad_lrck, ad_sclk  out  1 each  ADC pins; identical to the DAC copies.
- ad_sdout  in  1  ADC serial data; pre-synchronised externally.
- sts_tx_underflow  out  1  sticky flag.
- sts_rx_overflow  out  1  sticky flag.

Behaviour:
- Reset: all outputs are 0, including rx data, rx_valid, tx_ready, LRCK, SCLK, SDIN and status. Frame counter is 0. TX shift data is 0.
- Counter and enable: frame counter cnt runs 0..L-1 with L = 64*MCLK_PER_SCLK, wraps to 0, and advances only while cfg_enable=1. While cfg_enable=0, cnt is forced to 0, all pins drive 0 and tx_ready is 0.
- Derived timing:
  - Bit slot b = cnt / MCLK_PER_SCLK (0..63).
  - Phase p = cnt % MCLK_PER_SCLK.
  - SCLK is registered: 0 for p < MCLK_PER_SCLK/2, else 1.
  - LRCK is registered: 0 for b < 32 (left), 1 for b >= 32 (right).
  - LRCK and SDIN change only at p=0, i.e. on the SCLK falling edge.
- I2S slot mapping: half-frame slot s = b % 32.
  - Slot 0 carries 0 (the one-SCLK I2S delay).
  - Slots 1..DATA_WIDTH carry MSB first.
  - Remaining slots carry 0.
  - Left data goes in the first half-frame, right data in the second.
- TX handshake:
  - At cnt = L-1, tx_ready = 1 for that single cycle.
  - If tx_valid=1, the pair is loaded for the next frame.
  - If tx_valid=0, zeros are loaded and sts_tx_underflow is set.
  - tx_ready is never high on any other cycle.
- RX capture:
  - ad_sdout is sampled at p = MCLK_PER_SCLK/2 (SCLK rising edge) in slots 1..DATA_WIDTH of each half-frame.
  - Left and right are assembled into internal shift registers.
- RX handshake:
  - At cnt = L-1, rx_left/rx_right are updated from the assembled pair and rx_valid is set to 1.
  - If rx_valid was still 1 at that point and rx_ready was 0, sts_rx_overflow is set and the data is overwritten.
  - A transfer occurs when rx_valid && rx_ready. rx_valid clears the next cycle unless a new frame completes in the same cycle, in which case it stays 1 with new data and no overflow is flagged.
  - rx_data is stable while rx_valid=1 outside the frame-end cycle.
- First frame after enable: TX outputs zeros because nothing has been loaded yet, and underflow is not flagged. The first rx_valid is raised at the end of the first complete frame.
- Disable mid-frame:
  - cnt is forced to 0 on the next cycle.
  - The partial RX frame is discarded.
  - rx_valid is cleared.
  - The TX shift data is zeroed.
  - Re-enable starts a fresh frame.
- Status:
  - cmd_clear_status clears both flags.
  - A set event in the same cycle as a clear wins, so the flag stays 1.
- rst mid-operation: behaves identically to the reset values above on the next edge.

Test Plan:
1. Reset with cfg_enable=1 -> all outputs 0. After release, da_sclk period is 8 clk, da_lrck period is 512 clk, and da_lrck rises at cnt=256.
2. tx_valid held with L=0xA5A5A5, R=0x5A5A5A -> tx_ready pulses once per 512 clk. In the next frame da_sdin in slots 1..24 reads A5A5A5 MSB first (left) and 5A5A5A (right); slots 0 and 25..31 are 0.
3. ad_sdout driven by a model of L=0x800001, R=0x7FFFFF -> after cnt=511, rx_valid=1 with rx_left=0x800001 and rx_right=0x7FFFFF; rx_ready=1 clears it next cycle.
4. tx_valid=0 at one frame boundary -> sts_tx_underflow=1 and that frame's da_sdin is all 0. cmd_clear_status -> flag returns to 0.
5. rx_ready held 0 across two frame ends -> second frame sets sts_rx_overflow and rx data shows the newest pair. A clear coincident with a new overflow event leaves the flag at 1.
6. cfg_enable dropped at cnt=300 -> pins are 0 and rx_valid is 0 next cycle. Re-enable gives da_lrck low for 256 clk and the first rx_valid 512 clk later.

Source files
------------

// File: rtl/i2s2_frame_ctrl.sv
// I2S frame controller: derives SCLK/LRCK from MCLK, serialises DAC pairs, deserialises ADC pairs.
// Latency: a TX pair accepted at frame end plays in the next frame; an RX pair is presented at the end of its frame.
// Backpressure: tx_ready pulses once per frame (zeros play if no pair is offered); an unconsumed RX pair is overwritten and flagged.
module i2s2_frame_ctrl #(
  parameter int DATA_WIDTH    = 24,
  parameter int MCLK_PER_SCLK = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_enable,
  input  logic                  cmd_clear_status,
  input  logic [DATA_WIDTH-1:0] tx_left,
  input  logic [DATA_WIDTH-1:0] tx_right,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_left,
  output logic [DATA_WIDTH-1:0] rx_right,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  da_lrck,
  output logic                  da_sclk,
  output logic                  da_sdin,
  output logic                  ad_lrck,
  output logic                  ad_sclk,
  input  logic                  ad_sdout,
  output logic                  sts_tx_underflow,
  output logic                  sts_rx_overflow
);

  localparam int FRAME_LEN = 64 * MCLK_PER_SCLK;
  localparam int CW        = $clog2(FRAME_LEN);
  localparam int PW        = $clog2(MCLK_PER_SCLK);

  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  sclk_q, sclk_d;
  logic                  lrck_q, lrck_d;
  logic                  sdin_q, sdin_d;
  logic                  tx_ready_q, tx_ready_d;
  logic [DATA_WIDTH-1:0] tx_l_q, tx_r_q;
  logic [DATA_WIDTH-1:0] rx_sh_l_q, rx_sh_r_q;
  logic [DATA_WIDTH-1:0] rx_l_q, rx_r_q;
  logic                  rx_valid_q;
  logic                  unf_q, ovf_q;

  logic [4:0]            nslot, slot_q, tx_idx;
  logic                  frame_end, rx_sample, unf_set, ovf_set;

  always_comb begin
    cnt_d = '0;
    if (cfg_enable) cnt_d = (cnt_q == CW'(FRAME_LEN - 1)) ? '0 : cnt_q + CW'(1);

    // Pins are registered from the next count so they line up with cnt_q.
    nslot      = cnt_d[PW+4:PW];
    tx_idx     = 5'(DATA_WIDTH) - nslot;
    sclk_d     = cfg_enable & cnt_d[PW-1];
    lrck_d     = cfg_enable & cnt_d[CW-1];
    tx_ready_d = cfg_enable & (cnt_d == CW'(FRAME_LEN - 1));
    sdin_d     = 1'b0;
    if (cfg_enable && nslot != 5'd0 && int'(nslot) <= DATA_WIDTH)
      sdin_d = cnt_d[CW-1] ? tx_r_q[tx_idx] : tx_l_q[tx_idx];

    slot_q    = cnt_q[PW+4:PW];
    frame_end = cfg_enable & (cnt_q == CW'(FRAME_LEN - 1));
    rx_sample = cfg_enable && (cnt_q[PW-1:0] == PW'(MCLK_PER_SCLK / 2)) &&
                slot_q != 5'd0 && int'(slot_q) <= DATA_WIDTH;
    unf_set   = tx_ready_q & cfg_enable & ~tx_valid;
    ovf_set   = frame_end & rx_valid_q & ~rx_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      sclk_q     <= 1'b0;
      lrck_q     <= 1'b0;
      sdin_q     <= 1'b0;
      tx_ready_q <= 1'b0;
      tx_l_q     <= '0;
      tx_r_q     <= '0;
      rx_sh_l_q  <= '0;
      rx_sh_r_q  <= '0;
      rx_l_q     <= '0;
      rx_r_q     <= '0;
      rx_valid_q <= 1'b0;
      unf_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      sclk_q     <= sclk_d;
      lrck_q     <= lrck_d;
      sdin_q     <= sdin_d;
      tx_ready_q <= tx_ready_d;

      if (!cfg_enable) begin
        tx_l_q <= '0;
        tx_r_q <= '0;
      end else if (tx_ready_q) begin
        tx_l_q <= tx_valid ? tx_left  : '0;
        tx_r_q <= tx_valid ? tx_right : '0;
      end

      if (!cfg_enable) begin
        rx_sh_l_q <= '0;
        rx_sh_r_q <= '0;
      end else if (rx_sample) begin
        if (cnt_q[CW-1]) rx_sh_r_q <= {rx_sh_r_q[DATA_WIDTH-2:0], ad_sdout};
        else             rx_sh_l_q <= {rx_sh_l_q[DATA_WIDTH-2:0], ad_sdout};
      end

      // A frame completing in the same cycle as a transfer keeps rx_valid high.
      if (!cfg_enable) begin
        rx_valid_q <= 1'b0;
      end else if (frame_end) begin
        rx_l_q     <= rx_sh_l_q;
        rx_r_q     <= rx_sh_r_q;
        rx_valid_q <= 1'b1;
      end else if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end

      unf_q <= (unf_q & ~cmd_clear_status) | unf_set;
      ovf_q <= (ovf_q & ~cmd_clear_status) | ovf_set;
    end
  end

  assign tx_ready         = tx_ready_q;
  assign rx_left          = rx_l_q;
  assign rx_right         = rx_r_q;
  assign rx_valid         = rx_valid_q;
  assign da_lrck          = lrck_q;
  assign da_sclk          = sclk_q;
  assign da_sdin          = sdin_q;
  assign ad_lrck          = lrck_q;
  assign ad_sclk          = sclk_q;
  assign sts_tx_underflow = unf_q;
  assign sts_rx_overflow  = ovf_q;

endmodule

// File: tb/tb_i2s2_frame_ctrl.sv
// Directed bench for i2s2_frame_ctrl with an ADC serial model driven from a shadow frame count.
module tb_i2s2_frame_ctrl;

  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          rst, cfg_enable, cmd_clear_status;
  logic [DW-1:0] tx_left, tx_right, rx_left, rx_right;
  logic          tx_valid, tx_ready, rx_valid, rx_ready;
  logic          da_lrck, da_sclk, da_sdin, ad_lrck, ad_sclk, ad_sdout;
  logic          sts_tx_underflow, sts_rx_overflow;

  logic [DW-1:0] rxm_l, rxm_r;
  int            tcnt = 0;
  int            n_pass = 0, n_total = 0, rdy_cnt = 0, k;
  logic          or_sdin;
  logic [DW-1:0] word;
  logic          exp_bit;

  i2s2_frame_ctrl #(.DATA_WIDTH(DW), .MCLK_PER_SCLK(8)) dut (
    .clk(clk), .rst(rst), .cfg_enable(cfg_enable), .cmd_clear_status(cmd_clear_status),
    .tx_left(tx_left), .tx_right(tx_right), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_left(rx_left), .rx_right(rx_right), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .da_lrck(da_lrck), .da_sclk(da_sclk), .da_sdin(da_sdin),
    .ad_lrck(ad_lrck), .ad_sclk(ad_sclk), .ad_sdout(ad_sdout),
    .sts_tx_underflow(sts_tx_underflow), .sts_rx_overflow(sts_rx_overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst || !cfg_enable) tcnt <= 0;
    else                    tcnt <= (tcnt == 511) ? 0 : tcnt + 1;
  end

  function automatic logic adc_bit(input int c, input logic [DW-1:0] l, input logic [DW-1:0] r);
    int s;
    logic [DW-1:0] w;
    s = (c / 8) % 32;
    w = (c / 8 < 32) ? l : r;
    adc_bit = (s >= 1 && s <= DW) ? w[DW-s] : 1'b0;
  endfunction

  assign ad_sdout = adc_bit(tcnt, rxm_l, rxm_r);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (tx_ready) rdy_cnt++;
  endtask

  task automatic goto(input int c);
    int n;
    n = 0;
    while (tcnt != c && n < 1100) begin
      tick();
      n++;
    end
    if (tcnt != c) chk("goto_timeout", 32'(tcnt), 32'(c));
  endtask

  initial begin
    rst = 1; cfg_enable = 1; cmd_clear_status = 0;
    tx_valid = 1; tx_left = 24'hA5A5A5; tx_right = 24'h5A5A5A; rx_ready = 0;
    rxm_l = 24'h800001; rxm_r = 24'h7FFFFF;
    repeat (3) tick();

    // Reset state
    chk("rst_tx_ready", 32'(tx_ready), 0);
    chk("rst_rx_valid", 32'(rx_valid), 0);
    chk("rst_rx_left", 32'(rx_left), 0);
    chk("rst_rx_right", 32'(rx_right), 0);
    chk("rst_pins", {26'd0, da_lrck, da_sclk, da_sdin, ad_lrck, ad_sclk, 1'b0}, 0);
    chk("rst_status", {30'd0, sts_tx_underflow, sts_rx_overflow}, 0);
    rst = 0;

    // Clock derivation, first frame
    goto(3);   chk("sclk_p3", 32'(da_sclk), 0);
    goto(4);   chk("sclk_p4", 32'(da_sclk), 1);
    goto(8);   chk("sclk_p8", 32'(da_sclk), 0);
    goto(12);  chk("sclk_p12", 32'(ad_sclk), 1);
               chk("first_frame_sdin", 32'(da_sdin), 0);
    goto(255); chk("lrck_255", 32'(da_lrck), 0);
    goto(256); chk("lrck_256", 32'(da_lrck), 1);
               chk("ad_lrck_256", 32'(ad_lrck), 1);
    goto(511); chk("tx_ready_511", 32'(tx_ready), 1);
    tick();
    chk("tx_ready_0", 32'(tx_ready), 0);
    chk("lrck_0", 32'(da_lrck), 0);
    chk("rx_valid_f1", 32'(rx_valid), 1);
    chk("rx_left_f1", 32'(rx_left), 32'h800001);
    chk("rx_right_f1", 32'(rx_right), 32'h7FFFFF);
    chk("no_unf_first", 32'(sts_tx_underflow), 0);
    rx_ready = 1;
    tick();
    chk("rx_valid_cleared", 32'(rx_valid), 0);
    rx_ready = 0;
    rdy_cnt = 0;

    // Frame 2 plays the pair accepted at the end of frame 1
    for (int b = 0; b < 64; b++) begin
      goto(b * 8 + 4);
      word = (b < 32) ? 24'hA5A5A5 : 24'h5A5A5A;
      exp_bit = ((b % 32) >= 1 && (b % 32) <= DW) ? word[DW - (b % 32)] : 1'b0;
      chk($sformatf("sdin_slot%0d", b), 32'(da_sdin), 32'(exp_bit));
    end

    // Underflow at the frame 2 boundary
    tx_valid = 0;
    goto(511); chk("tx_ready_f2", 32'(tx_ready), 1);
    tick();
    chk("tx_ready_once", 32'(rdy_cnt), 1);
    chk("unf_set", 32'(sts_tx_underflow), 1);
    chk("rx_valid_f2", 32'(rx_valid), 1);
    chk("no_ovf_f2", 32'(sts_rx_overflow), 0);
    tx_valid = 1;
    rxm_l = 24'h123456; rxm_r = 24'h654321;
    or_sdin = da_sdin;
    for (int i = 0; i < 511; i++) begin
      cmd_clear_status = (tcnt == 100);
      tick();
      or_sdin |= da_sdin;
    end
    chk("unf_frame_zero", 32'(or_sdin), 0);
    chk("unf_cleared", 32'(sts_tx_underflow), 0);

    // Overflow: rx_ready held low across frame ends 2 and 3
    tick();
    chk("ovf_set", 32'(sts_rx_overflow), 1);
    chk("ovf_rx_valid", 32'(rx_valid), 1);
    chk("ovf_rx_left", 32'(rx_left), 32'h123456);
    chk("ovf_rx_right", 32'(rx_right), 32'h654321);
    goto(12);  chk("f4_slot1", 32'(da_sdin), 1);
    goto(20);  chk("f4_slot2", 32'(da_sdin), 0);
    goto(100);
    cmd_clear_status = 1; tick(); cmd_clear_status = 0;
    chk("ovf_cleared", 32'(sts_rx_overflow), 0);
    goto(511);
    cmd_clear_status = 1; tick(); cmd_clear_status = 0;
    chk("ovf_set_wins", 32'(sts_rx_overflow), 1);

    // Disable mid-frame and re-enable
    goto(300);
    chk("pre_dis_sclk", 32'(da_sclk), 1);
    chk("pre_dis_lrck", 32'(da_lrck), 1);
    cfg_enable = 0;
    tick();
    chk("dis_pins", {27'd0, da_lrck, da_sclk, da_sdin, ad_lrck, ad_sclk}, 0);
    chk("dis_rx_valid", 32'(rx_valid), 0);
    chk("dis_tx_ready", 32'(tx_ready), 0);
    repeat (5) tick();
    chk("dis_hold_sclk", 32'(da_sclk), 0);
    cfg_enable = 1;
    k = 0; or_sdin = 1'b0;
    while (!da_lrck && k < 600) begin
      tick(); k++;
      if (!da_lrck) or_sdin |= da_sdin;
    end
    chk("reen_lrck_low_len", 32'(k), 256);
    chk("reen_tx_zeroed", 32'(or_sdin), 0);
    while (!rx_valid && k < 1200) begin
      tick(); k++;
    end
    chk("reen_first_rx_valid", 32'(k), 512);
    chk("reen_rx_left", 32'(rx_left), 32'h123456);

    // Reset during operation
    rst = 1;
    tick();
    chk("mid_rst_rx_left", 32'(rx_left), 0);
    chk("mid_rst_rx_valid", 32'(rx_valid), 0);
    chk("mid_rst_ovf", 32'(sts_rx_overflow), 0);
    chk("mid_rst_sclk", 32'(da_sclk), 0);
    rst = 0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
